rv32i_fetch_stage: RTL and testbench



---
 rtl/rv32i_fetch_stage.sv | 140 ++++++++++++++
 tb/tb_rv32i_fetch_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_stage.sv
// rv32i fetch stage: owns the PC, fetches over a strobe/ack port
// and feeds decode with bubble/hold semantics.
module rv32i_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_ce,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_change_pc,
    input  logic [31:0] i_next_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic [31:0] held;
    logic [31:0] held_n;
    logic [31:0] iaddr_n;
    logic [31:0] inst_n;
    logic [31:0] opc_n;
    logic        stb_n;
    logic        ce_n;
    logic [31:0] pc_inc;
    logic [31:0] redir_pc;
    logic        ack;

    assign pc_inc   = pc + 32'd4;
    assign redir_pc = {i_next_pc[31:2], 2'b00};
    // an ack only counts while a request is actually outstanding
    assign ack      = i_ack_inst & o_stb_inst;

    // state and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            pc         <= PC_RESET;
            held       <= 32'd0;
            o_iaddr    <= PC_RESET;
            o_stb_inst <= 1'b0;
            o_inst     <= 32'd0;
            o_pc       <= 32'd0;
            o_ce       <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            held       <= held_n;
            o_iaddr    <= iaddr_n;
            o_stb_inst <= stb_n;
            o_inst     <= inst_n;
            o_pc       <= opc_n;
            o_ce       <= ce_n;
        end
    end

    // next state: redirect > flush > per-state fetch/hold handling
    always_comb begin
        state_n = state;
        pc_n    = pc;
        held_n  = held;
        iaddr_n = o_iaddr;
        stb_n   = o_stb_inst;
        inst_n  = o_inst;
        opc_n   = o_pc;
        ce_n    = o_ce;
        if (i_change_pc) begin
            pc_n    = redir_pc;
            iaddr_n = redir_pc;
            stb_n   = 1'b0;
            ce_n    = 1'b0;
            held_n  = 32'd0;
            state_n = S_IDLE;
        end else if (i_flush) begin
            iaddr_n = pc;
            stb_n   = 1'b0;
            ce_n    = 1'b0;
            held_n  = 32'd0;
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    stb_n   = 1'b1;
                    iaddr_n = pc;
                    ce_n    = 1'b0;
                    state_n = S_REQ;
                end
                S_REQ: begin
                    unique case ({ack, i_stall})
                        2'b10: begin
                            inst_n  = i_inst;
                            opc_n   = pc;
                            ce_n    = 1'b1;
                            pc_n    = pc_inc;
                            iaddr_n = pc_inc;
                        end
                        2'b11: begin
                            held_n  = i_inst;
                            stb_n   = 1'b0;
                            state_n = S_HOLD;
                        end
                        2'b00: begin
                            ce_n = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        inst_n  = held;
                        opc_n   = pc;
                        ce_n    = 1'b1;
                        pc_n    = pc_inc;
                        iaddr_n = pc_inc;
                        stb_n   = 1'b1;
                        state_n = S_REQ;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Directed bench for rv32i_fetch_stage: streaming, stall hold,
// wait states, redirect, flush, PC wrap and async reset.
module tb_rv32i_fetch_stage;

    localparam logic [31:0] C = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic [31:0] iaddr;
    logic        stb;
    logic        ack;
    logic [31:0] inst;
    logic [31:0] oinst;
    logic [31:0] opc;
    logic        ce;
    logic        stall;
    logic        flush;
    logic        chg;
    logic [31:0] npc;

    logic        rst2;
    logic [31:0] iaddr2;
    logic        stb2;
    logic        ack2;
    logic [31:0] inst2;
    logic [31:0] oinst2;
    logic [31:0] opc2;
    logic        ce2;

    int tests = 0;
    int fails = 0;

    // memory model: instruction word derived from its address
    assign inst  = iaddr ^ C;
    assign inst2 = iaddr2 ^ C;

    rv32i_fetch_stage dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_iaddr     (iaddr),
        .o_stb_inst  (stb),
        .i_ack_inst  (ack),
        .i_inst      (inst),
        .o_inst      (oinst),
        .o_pc        (opc),
        .o_ce        (ce),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_change_pc (chg),
        .i_next_pc   (npc)
    );

    rv32i_fetch_stage #(.PC_RESET(32'hFFFF_FFF8)) dut2 (
        .i_clk       (clk),
        .i_rst       (rst2),
        .o_iaddr     (iaddr2),
        .o_stb_inst  (stb2),
        .i_ack_inst  (ack2),
        .i_inst      (inst2),
        .o_inst      (oinst2),
        .o_pc        (opc2),
        .o_ce        (ce2),
        .i_stall     (stall),
        .i_flush     (flush),
        .i_change_pc (chg),
        .i_next_pc   (npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({iaddr, stb, ce, oinst, opc} !== {32'd0, 1'b0, 1'b0, 64'd0}) begin
            fails++;
            $display("FAIL reset: iaddr=%h stb=%b ce=%b inst=%h pc=%h", iaddr, stb, ce, oinst, opc);
        end
        tests++;
        if (iaddr2 !== 32'hFFFF_FFF8 || stb2 !== 1'b0 || ce2 !== 1'b0) begin
            fails++;
            $display("FAIL reset2: iaddr=%h stb=%b ce=%b want fffffff8 0 0", iaddr2, stb2, ce2);
        end
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({stb, ce, iaddr} !== {1'b1, 1'b0, 32'd0}) begin
            fails++;
            $display("FAIL first_req: stb=%b ce=%b iaddr=%h want 1 0 0", stb, ce, iaddr);
        end
    endtask

    task automatic test_back_to_back();
        ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++;
            if ({ce, stb, opc, oinst, iaddr} !== {1'b1, 1'b1, k * 4, (k * 4) ^ C, k * 4 + 4}) begin
                fails++;
                $display("FAIL b2b[%0d]: ce=%b stb=%b pc=%h inst=%h iaddr=%h", k, ce, stb, opc, oinst, iaddr);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if ({stb, ce, opc, oinst, iaddr} !== {1'b0, 1'b1, 32'd4, 32'd4 ^ C, 32'd8}) begin
                fails++;
                $display("FAIL stall[%0d]: stb=%b ce=%b pc=%h inst=%h iaddr=%h want 0 1 4 %h 8", k, stb, ce, opc, oinst, iaddr, 32'd4 ^ C);
            end
        end
        stall = 1'b0;
        ack = 1'b0;
        tick();
        tests++;
        if ({stb, ce, opc, oinst, iaddr} !== {1'b1, 1'b1, 32'd8, 32'd8 ^ C, 32'd12}) begin
            fails++;
            $display("FAIL stall_release: stb=%b ce=%b pc=%h inst=%h iaddr=%h", stb, ce, opc, oinst, iaddr);
        end
        ack = 1'b1;
        tick();
        tests++;
        if ({ce, opc, iaddr} !== {1'b1, 32'd12, 32'd16}) begin
            fails++;
            $display("FAIL stall_resume: ce=%b pc=%h iaddr=%h want 1 c 10", ce, opc, iaddr);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] a;
        logic        e;
        a = 32'd16;
        for (int j = 0; j < 9; j++) begin
            e = (j % 3 == 2);
            ack = e;
            tick();
            if (e) a = a + 32'd4;
            tests++;
            if (ce !== e || iaddr !== a || stb !== 1'b1 || (e && opc !== a - 32'd4)) begin
                fails++;
                $display("FAIL wait[%0d]: ce=%b iaddr=%h pc=%h want ce=%b iaddr=%h", j, ce, iaddr, opc, e, a);
            end
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1;
        ack = 1'b1;
        chg = 1'b1;
        npc = 32'h0000_1003;
        tick();
        tests++;
        if ({ce, stb, iaddr} !== {1'b0, 1'b0, 32'h1000}) begin
            fails++;
            $display("FAIL redirect: ce=%b stb=%b iaddr=%h want 0 0 1000", ce, stb, iaddr);
        end
        chg = 1'b0;
        stall = 1'b0;
        ack = 1'b0;
        tick();
        tests++;
        if ({ce, stb, iaddr} !== {1'b0, 1'b1, 32'h1000}) begin
            fails++;
            $display("FAIL redirect_req: ce=%b stb=%b iaddr=%h want 0 1 1000", ce, stb, iaddr);
        end
        ack = 1'b1;
        tick();
        tests++;
        if ({ce, opc, oinst} !== {1'b1, 32'h1000, 32'h1000 ^ C}) begin
            fails++;
            $display("FAIL redirect_issue: ce=%b pc=%h inst=%h want 1 1000", ce, opc, oinst);
        end
    endtask

    task automatic test_flush();
        chg = 1'b1;
        npc = 32'd20;
        ack = 1'b0;
        tick();
        chg = 1'b0;
        tick();
        ack = 1'b1;
        stall = 1'b1;
        tick();
        tests++;
        if ({stb, ce, iaddr} !== {1'b0, 1'b0, 32'd20}) begin
            fails++;
            $display("FAIL flush_hold: stb=%b ce=%b iaddr=%h want 0 0 14", stb, ce, iaddr);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        ack = 1'b0;
        tests++;
        if ({ce, stb, iaddr} !== {1'b0, 1'b0, 32'd20}) begin
            fails++;
            $display("FAIL flush: ce=%b stb=%b iaddr=%h want 0 0 14", ce, stb, iaddr);
        end
        tick();
        tests++;
        if ({ce, stb, iaddr} !== {1'b0, 1'b1, 32'd20}) begin
            fails++;
            $display("FAIL flush_drop: ce=%b stb=%b iaddr=%h want 0 1 14", ce, stb, iaddr);
        end
        ack = 1'b1;
        tick();
        tests++;
        if ({ce, opc, oinst, iaddr} !== {1'b1, 32'd20, 32'd20 ^ C, 32'd24}) begin
            fails++;
            $display("FAIL refetch: ce=%b pc=%h inst=%h iaddr=%h want 1 14", ce, opc, oinst, iaddr);
        end
    endtask

    task automatic test_async_reset();
        ack = 1'b1;
        stall = 1'b1;
        tick();
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({iaddr, stb, ce, oinst, opc} !== {32'd0, 1'b0, 1'b0, 64'd0}) begin
            fails++;
            $display("FAIL async_rst: iaddr=%h stb=%b ce=%b inst=%h pc=%h", iaddr, stb, ce, oinst, opc);
        end
        #1;
        rst = 1'b0;
        stall = 1'b0;
        tick();
        tests++;
        if ({ce, stb, iaddr} !== {1'b0, 1'b1, 32'd0}) begin
            fails++;
            $display("FAIL post_rst: ce=%b stb=%b iaddr=%h want 0 1 0", ce, stb, iaddr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        ack2 = 1'b1;
        rst2 = 1'b0;
        tick();
        tests++;
        if ({stb2, ce2, iaddr2} !== {1'b1, 1'b0, 32'hFFFF_FFF8}) begin
            fails++;
            $display("FAIL wrap_req: stb=%b ce=%b iaddr=%h", stb2, ce2, iaddr2);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if ({ce2, opc2, oinst2} !== {1'b1, exp_pc[k], exp_pc[k] ^ C}) begin
                fails++;
                $display("FAIL wrap[%0d]: ce=%b pc=%h inst=%h want pc=%h", k, ce2, opc2, oinst2, exp_pc[k]);
            end
        end
        tests++;
        if (iaddr2 !== 32'd4) begin
            fails++;
            $display("FAIL wrap_iaddr: iaddr=%h want 4", iaddr2);
        end
    endtask

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        ack = 1'b0;
        ack2 = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        chg = 1'b0;
        npc = 32'd0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_wait_states();
        test_redirect();
        test_flush();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
